alu_sequencer: RTL and testbench

Command-side initiator for the 4-bit ALU. It accepts operation commands over a valid/ready handshake and drives registered operands and select onto the ALU input ports. It then captures the ALU result and carry and returns them with flags over a response handshake. A 4-bit accumulator allows chained operations, for example A+B followed by NOT of the result.

---
 rtl/alu_sequencer_pkg.sv | 25 ++
 rtl/alu_sequencer_if.sv | 34 +++
 rtl/alu_sequencer_alu.sv | 32 +++
 rtl/alu_sequencer.sv | 89 ++++++++
 tb/tb_alu_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer and the 4-bit ALU it drives.
// Holds the opcode encodings, the FSM state type and the opcode legality check.
package alu_sequencer_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'd0;
    localparam logic [OP_W-1:0] OP_OR  = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR = 3'd2;
    localparam logic [OP_W-1:0] OP_ADD = 3'd3;
    localparam logic [OP_W-1:0] OP_NOT = 3'd4;
    localparam logic [OP_W-1:0] OP_SUB = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Encodings 6 and 7 have no ALU function behind them.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_SUB);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response handshake bundle between a requester and the ALU sequencer.
// The master side issues commands and consumes responses; the slave side is the sequencer.
interface alu_sequencer_if
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic              cmd_use_acc;
    logic [WIDTH-1:0]  cmd_a;
    logic [WIDTH-1:0]  cmd_b;
    logic              cmd_wr_acc;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_carry;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_use_acc, cmd_a, cmd_b, cmd_wr_acc, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_use_acc, cmd_a, cmd_b, cmd_wr_acc, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational WIDTH-bit ALU driven by the sequencer's registered operand ports.
// Carry is the adder carry-out for ADD and the borrow for SUB; zero otherwise.
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  select,
    output logic [WIDTH-1:0] result_c,
    output logic             carry_c
);

    always_comb begin
        result_c = '0;
        carry_c  = 1'b0;
        case (select)
            OP_AND: result_c = a & b;
            OP_OR:  result_c = a | b;
            OP_XOR: result_c = a ^ b;
            OP_ADD: {carry_c, result_c} = {1'b0, a} + {1'b0, b};
            OP_NOT: result_c = ~a;
            OP_SUB: {carry_c, result_c} = {1'b0, a} - {1'b0, b};
            default: begin
                result_c = '0;
                carry_c  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Command-side initiator for the ALU: registers operands onto the ALU ports, captures
// the result one cycle later and returns it with flags; keeps an accumulator for chaining.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_sequencer_if.slave   bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_select,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic [WIDTH-1:0] acc
);

    state_e          state;
    logic            wr_acc_q;
    logic [OP_W-1:0] op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wr_acc_q       <= 1'b0;
            op_q           <= '0;
            acc            <= ACC_INIT;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_select     <= '0;
            bus.cmd_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.cmd_ready <= 1'b0;
                        if (is_legal_op(bus.cmd_op)) begin
                            alu_a      <= bus.cmd_use_acc ? acc : bus.cmd_a;
                            alu_b      <= bus.cmd_b;
                            alu_select <= bus.cmd_op;
                            op_q       <= bus.cmd_op;
                            wr_acc_q   <= bus.cmd_wr_acc;
                            state      <= ST_EXEC;
                        end else begin
                            // Illegal op answers immediately with the accumulator; ALU ports untouched.
                            bus.rsp_result <= acc;
                            bus.rsp_carry  <= 1'b0;
                            bus.rsp_zero   <= (acc == WIDTH'(0));
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_valid  <= 1'b1;
                            state          <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    bus.rsp_result <= alu_out;
                    bus.rsp_carry  <= (op_q == OP_ADD) ? alu_carry : 1'b0;
                    bus.rsp_zero   <= (alu_out == WIDTH'(0));
                    bus.rsp_err    <= 1'b0;
                    bus.rsp_valid  <= 1'b1;
                    if (wr_acc_q) begin
                        acc <= alu_out;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer wired to the combinational ALU.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OP_W-1:0]  alu_select;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic [WIDTH-1:0] acc;

    int checks = 0;
    int errors = 0;

    alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_sequencer #(.WIDTH(WIDTH), .ACC_INIT(4'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .acc        (acc)
    );

    alu_sequencer_alu #(.WIDTH(WIDTH)) alu (
        .a        (alu_a),
        .b        (alu_b),
        .select   (alu_select),
        .result_c (alu_out),
        .carry_c  (alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for cmd_ready, presents one command for exactly one accept edge.
    task automatic send_cmd(input logic [2:0] op, input logic use_acc, input logic [3:0] a,
                            input logic [3:0] b, input logic wr_acc);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) begin
            checks++; errors++;
            $display("FAIL send_cmd_timeout: cmd_ready=%b required 1", bus.cmd_ready);
        end
        bus.cmd_op = op; bus.cmd_use_acc = use_acc; bus.cmd_a = a; bus.cmd_b = b;
        bus.cmd_wr_acc = wr_acc; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (acc !== 4'h0) begin errors++; $display("FAIL reset_acc: got %h want 0", acc); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (alu_select !== 3'd0) begin errors++; $display("FAIL reset_alu_select: got %0d want 0", alu_select); end
        checks++; if (alu_a !== 4'h0) begin errors++; $display("FAIL reset_alu_a: got %h want 0", alu_a); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_add_wr_acc();
        send_cmd(OP_ADD, 1'b0, 4'hA, 4'h7, 1'b1);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL add_exec_ready: got %b want 0", bus.cmd_ready); end
        checks++; if (alu_a !== 4'hA || alu_b !== 4'h7 || alu_select !== 3'd3) begin
            errors++; $display("FAIL add_alu_ports: got a=%h b=%h sel=%0d want a=a b=7 sel=3", alu_a, alu_b, alu_select);
        end
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_result !== 4'h1) begin errors++; $display("FAIL add_result: got %h want 1", bus.rsp_result); end
        checks++; if (bus.rsp_carry !== 1'b1) begin errors++; $display("FAIL add_carry: got %b want 1", bus.rsp_carry); end
        checks++; if (bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL add_flags: got zero=%b err=%b want 0 0", bus.rsp_zero, bus.rsp_err);
        end
        checks++; if (acc !== 4'h1) begin errors++; $display("FAIL add_acc: got %h want 1", acc); end
        finish_rsp();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL add_handshake: got valid=%b ready=%b want 0 1", bus.rsp_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_chain();
        send_cmd(OP_NOT, 1'b1, 4'h0, 4'h0, 1'b1);
        checks++; if (alu_a !== 4'h1) begin errors++; $display("FAIL not_alu_a: got %h want 1", alu_a); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_result !== 4'hE || bus.rsp_carry !== 1'b0) begin
            errors++; $display("FAIL not_result: got %h c=%b want e c=0", bus.rsp_result, bus.rsp_carry);
        end
        checks++; if (acc !== 4'hE) begin errors++; $display("FAIL not_acc: got %h want e", acc); end
        finish_rsp();
        send_cmd(OP_SUB, 1'b1, 4'h3, 4'hE, 1'b1);
        checks++; if (alu_a !== 4'hE || alu_select !== 3'd5) begin
            errors++; $display("FAIL sub_ports: got a=%h sel=%0d want e 5", alu_a, alu_select);
        end
        @(posedge clk); #1;
        checks++; if (bus.rsp_result !== 4'h0 || bus.rsp_zero !== 1'b1 || bus.rsp_carry !== 1'b0) begin
            errors++; $display("FAIL sub_result: got %h z=%b c=%b want 0 z=1 c=0", bus.rsp_result, bus.rsp_zero, bus.rsp_carry);
        end
        checks++; if (acc !== 4'h0) begin errors++; $display("FAIL sub_acc: got %h want 0", acc); end
        finish_rsp();
    endtask

    task automatic test_illegal();
        send_cmd(OP_ADD, 1'b0, 4'h5, 4'h0, 1'b1);
        @(posedge clk); #1;
        checks++; if (acc !== 4'h5 || bus.rsp_carry !== 1'b0) begin
            errors++; $display("FAIL setup_acc5: got acc=%h c=%b want 5 0", acc, bus.rsp_carry);
        end
        finish_rsp();
        send_cmd(3'd6, 1'b0, 4'hF, 4'hF, 1'b1);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL illegal_latency: got %b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_result !== 4'h5) begin
            errors++; $display("FAIL illegal_rsp: got err=%b res=%h want 1 5", bus.rsp_err, bus.rsp_result);
        end
        checks++; if (bus.rsp_zero !== 1'b0 || bus.rsp_carry !== 1'b0) begin
            errors++; $display("FAIL illegal_flags: got z=%b c=%b want 0 0", bus.rsp_zero, bus.rsp_carry);
        end
        checks++; if (alu_a !== 4'h5 || alu_b !== 4'h0 || alu_select !== 3'd3) begin
            errors++; $display("FAIL illegal_alu_hold: got a=%h b=%h sel=%0d want 5 0 3", alu_a, alu_b, alu_select);
        end
        finish_rsp();
        checks++; if (acc !== 4'h5) begin errors++; $display("FAIL illegal_acc: got %h want 5", acc); end
    endtask

    task automatic test_backpressure();
        send_cmd(OP_XOR, 1'b0, 4'hC, 4'hA, 1'b0);
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 4'h6) begin
            errors++; $display("FAIL xor_result: got v=%b res=%h want 1 6", bus.rsp_valid, bus.rsp_result);
        end
        // A competing command while the response is pending must be ignored.
        bus.cmd_op = OP_AND; bus.cmd_a = 4'h0; bus.cmd_b = 4'h0; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 4'h6 || bus.cmd_ready !== 1'b0 || alu_select !== 3'd2) begin
                errors++; $display("FAIL xor_hold[%0d]: got v=%b res=%h rdy=%b sel=%0d want 1 6 0 2",
                                   i, bus.rsp_valid, bus.rsp_result, bus.cmd_ready, alu_select);
            end
        end
        bus.cmd_valid = 1'b0;
        finish_rsp();
        checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || acc !== 4'h5) begin
            errors++; $display("FAIL xor_release: got rdy=%b v=%b acc=%h want 1 0 5", bus.cmd_ready, bus.rsp_valid, acc);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_rv [6];
        logic exp_cr [6];
        exp_rv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_cr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bus.cmd_op = OP_OR; bus.cmd_use_acc = 1'b0; bus.cmd_a = 4'h5; bus.cmd_b = 4'hA;
        bus.cmd_wr_acc = 1'b0; bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.rsp_valid !== exp_rv[i] || bus.cmd_ready !== exp_cr[i]) begin
                errors++; $display("FAIL b2b[%0d]: got v=%b rdy=%b want %b %b",
                                   i, bus.rsp_valid, bus.cmd_ready, exp_rv[i], exp_cr[i]);
            end
            if (exp_rv[i]) begin
                checks++; if (bus.rsp_result !== 4'hF) begin
                    errors++; $display("FAIL b2b_result[%0d]: got %h want f", i, bus.rsp_result);
                end
            end
        end
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen_valid;
        send_cmd(OP_AND, 1'b0, 4'hF, 4'h3, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++; if (acc !== 4'h0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_async: got acc=%h v=%b rdy=%b want 0 0 1", acc, bus.rsp_valid, bus.cmd_ready);
        end
        checks++; if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_select !== 3'd0) begin
            errors++; $display("FAIL midrst_alu: got a=%h b=%h sel=%0d want 0 0 0", alu_a, alu_b, alu_select);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid === 1'b1) seen_valid = 1'b1;
        end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", seen_valid); end
        checks++; if (acc !== 4'h0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_idle: got acc=%h rdy=%b want 0 1", acc, bus.cmd_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_use_acc = 1'b0;
        bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_wr_acc = 1'b0; bus.rsp_ready = 1'b0;
        test_reset();
        test_add_wr_acc();
        test_chain();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
